framebuffer_writer: RTL and testbench
=====================================

// Module: framebuffer_writer
// PURPOSE
//  Sits directly downstream of the circle painter. Consumes its pixel stream
//  (hcount/vcount + data_valid) and writes each pixel into the framebuffer BRAM.
//  Clips pixels that fall outside the frame, buffers bursts in a small FIFO,
//  and provides a full-frame clear sweep between frames.
// PARAMETERS
//  H_RES       320   frame width in pixels
//  V_RES       180   frame height in pixels
//  COLOR_W     16    pixel colour width
//  FIFO_DEPTH  16    pixel FIFO entries (power of 2)
//  ADDR_W      16    framebuffer address width; must satisfy 2**ADDR_W >= H_RES*V_RES
// PORTS
//  clk_in          in   1        system clock
//  rst_in          in   1        reset, asynchronous, active-low
//  hcount_in       in   11       pixel x from the painter
//  vcount_in       in   10       pixel y from the painter
//  data_valid_in   in   1        pixel valid, single-cycle strobe
//  color_in        in   COLOR_W  colour for the pixel
//  clear_in        in   1        request a full-frame clear (pulse)
//  clear_color_in  in   COLOR_W  fill colour, sampled on the accepted clear_in edge
//  fb_addr_out     out  ADDR_W   BRAM write address
//  fb_data_out     out  COLOR_W  BRAM write data
//  fb_we_out       out  1        BRAM write enable
//  busy_out        out  1        high while clearing or while the FIFO is non-empty
//  drop_count_out  out  16       pixels dropped on FIFO full; saturates at 16'hFFFF
//  clip_count_out  out  16       pixels rejected as off-frame; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst_in=0, async): all outputs 0, FIFO empty, state IDLE, counters 0.
//  Clip check:
//   - combinational on input; reject if hcount_in>=H_RES or vcount_in>=V_RES.
//   - covers painter wrap-around, e.g. hcount 11'h7FE.
//   - rejected pixel: clip_count+1; not enqueued.
//  Enqueue: valid and in-frame -> push {h,v,color}.
//   - FIFO full: push accepted only if a pop occurs on the same edge.
//   - otherwise the pixel is dropped and drop_count+1.
//  FSM, writer_state_t:
//   - IDLE: FIFO non-empty -> pop; go to DRAIN.
//   - DRAIN: pop one entry per cycle while non-empty; return to IDLE when empty.
//   - CLEAR: sweep addr 0..H_RES*V_RES-1, one write per cycle, data=clear_color;
//     after the last address go to DRAIN if the FIFO is non-empty, else IDLE.
//  clear_in in IDLE/DRAIN:
//   - flush the FIFO (discarded pixels are not counted);
//   - abort the in-flight write pipeline;
//   - go to CLEAR on the next edge.
//   - A pixel presented on the same cycle as clear_in is enqueued after the
//     flush and kept.
//  clear_in during CLEAR: ignored. Pixels arriving during CLEAR are enqueued
//   normally and written after the sweep.
//  Write pipeline (DRAIN):
//   - S0: pop.
//   - S1: addr = v*H_RES + h, registered.
//   - S2: fb_we_out=1 with addr/data.
//   - Latency data_valid_in -> fb_we_out = 3 cycles when idle and empty.
//   - Sustained throughput: 1 pixel/cycle.
//  CLEAR writes are driven directly, 1 cycle after entering CLEAR.
//   - fb_we_out is never asserted by both paths in one cycle.
//  Arithmetic:
//   - v*H_RES is computed at ADDR_W width; no overflow after the clip check.
//   - Sweep counter is ADDR_W wide; terminal value H_RES*V_RES-1.
//  busy_out = (state!=IDLE) | ~fifo_empty | pipeline valid.
//  Reset mid-sweep or mid-drain returns to IDLE; the BRAM is left partially
//   written, which is acceptable.
// STRUCTURE
//  fb_pkg: writer_state_t {IDLE, DRAIN, CLEAR}; pixel_t struct {h, v, color};
//   H_RES/V_RES defaults.
//  Sub-module sync_fifo: parameterised width/depth, push/pop/flush, full/empty.
//  Top level: clip logic, FSM, address pipeline, sweep counter, saturating counters.
// TESTING
//  1. Reset, then one pixel (h=5, v=2, color=16'hF800) -> 3 cycles later
//     we=1, addr=645, data=F800, exactly one write.
//  2. Off-frame pixels h=320 and h=11'h7FE -> no write, clip_count=2.
//  3. 20 back-to-back pixels, FIFO_DEPTH=16, pops blocked by CLEAR ->
//     drop_count=4, 16 writes after the sweep, in order.
//  4. clear_in with color 16'h001F from IDLE -> 57600 consecutive writes,
//     addr 0..57599, then busy_out=0.
//  5. clear_in and data_valid_in on the same cycle with 3 pixels already
//     queued -> the 3 queued pixels are discarded; the coincident pixel is
//     written after the sweep.
//  6. Assert rst_in=0 mid-sweep at addr 1000 -> outputs 0 immediately; with
//     no new input, no further writes.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer writer: FSM states, the
// queued pixel position, and a saturating 16-bit counter increment.
package fb_pkg;

    localparam int unsigned H_RES_DEF = 320;
    localparam int unsigned V_RES_DEF = 180;
    localparam int unsigned HCOUNT_W  = 11;
    localparam int unsigned VCOUNT_W  = 10;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } writer_state_t;

    // Colour travels alongside this struct so COLOR_W stays a top-level parameter.
    typedef struct packed {
        logic [HCOUNT_W-1:0] h;
        logic [VCOUNT_W-1:0] v;
    } pixel_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
// A push coinciding with a flush lands in the freshly emptied FIFO.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push, do_pop;
    logic [PTR_W-1:0] wr_idx;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_q];

    assign do_push = push_i & (flush_i | ~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign wr_idx  = flush_i ? '0 : wr_q;

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_idx] <= din_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= do_push ? PTR_W'(1) : '0;
            cnt_q <= do_push ? (PTR_W+1)'(1) : '0;
        end else begin
            if (do_push) wr_q <= wr_q + PTR_W'(1);
            if (do_pop)  rd_q <= rd_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/framebuffer_writer.sv
// Writes the painter's pixel stream into framebuffer BRAM: clips off-frame
// pixels, buffers bursts, and runs a full-frame clear sweep on request.
module framebuffer_writer
    import fb_pkg::*;
#(
    parameter int unsigned H_RES      = H_RES_DEF,
    parameter int unsigned V_RES      = V_RES_DEF,
    parameter int unsigned COLOR_W    = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [10:0]        hcount_in,
    input  logic [9:0]         vcount_in,
    input  logic               data_valid_in,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               clear_in,
    input  logic [COLOR_W-1:0] clear_color_in,
    output logic [ADDR_W-1:0]  fb_addr_out,
    output logic [COLOR_W-1:0] fb_data_out,
    output logic               fb_we_out,
    output logic               busy_out,
    output logic [15:0]        drop_count_out,
    output logic [15:0]        clip_count_out
);

    localparam int unsigned    FIFO_W     = $bits(pixel_t) + COLOR_W;
    localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(H_RES * V_RES - 1);

    writer_state_t      state_q;
    logic [ADDR_W-1:0]  sweep_q;
    logic [COLOR_W-1:0] clear_color_q;
    logic               s1_valid_q;
    logic [ADDR_W-1:0]  s1_addr_q, s1_addr_d;
    logic [COLOR_W-1:0] s1_color_q;
    logic [ADDR_W-1:0]  fb_addr_q;
    logic [COLOR_W-1:0] fb_data_q;
    logic               fb_we_q;
    logic [15:0]        drop_q, clip_q;

    logic               in_frame, pix_ok, clear_go, pop, push, drop;
    logic               fifo_full, fifo_empty;
    logic [FIFO_W-1:0]  fifo_din, fifo_dout;
    pixel_t             in_pix, head_pix;
    logic [COLOR_W-1:0] head_color;

    assign in_frame = (32'(hcount_in) < H_RES) && (32'(vcount_in) < V_RES);
    assign pix_ok   = data_valid_in & in_frame;
    assign clear_go = clear_in & (state_q != CLEAR);
    assign pop      = (state_q != CLEAR) & ~fifo_empty & ~clear_go;
    // When full, only a same-edge pop frees a slot; a flush empties it outright.
    assign push     = pix_ok & (clear_go | ~fifo_full | pop);
    assign drop     = pix_ok & ~push;

    assign in_pix.h = hcount_in;
    assign in_pix.v = vcount_in;
    assign fifo_din = {in_pix, color_in};
    assign {head_pix, head_color} = fifo_dout;

    assign s1_addr_d = ADDR_W'(head_pix.v) * ADDR_W'(H_RES) + ADDR_W'(head_pix.h);

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (clear_go),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= IDLE;
            sweep_q       <= '0;
            clear_color_q <= '0;
            s1_valid_q    <= 1'b0;
            s1_addr_q     <= '0;
            s1_color_q    <= '0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
            fb_we_q       <= 1'b0;
            drop_q        <= '0;
            clip_q        <= '0;
        end else begin
            if (data_valid_in && !in_frame) clip_q <= sat_inc16(clip_q);
            if (drop)                       drop_q <= sat_inc16(drop_q);

            s1_valid_q <= pop;
            s1_addr_q  <= s1_addr_d;
            s1_color_q <= head_color;

            unique case (state_q)
                IDLE, DRAIN: begin
                    fb_we_q   <= s1_valid_q & ~clear_go;
                    fb_addr_q <= s1_addr_q;
                    fb_data_q <= s1_color_q;
                    if (clear_go) begin
                        state_q       <= CLEAR;
                        sweep_q       <= '0;
                        clear_color_q <= clear_color_in;
                    end else if (fifo_empty) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                CLEAR: begin
                    fb_we_q   <= 1'b1;
                    fb_addr_q <= sweep_q;
                    fb_data_q <= clear_color_q;
                    sweep_q   <= sweep_q + ADDR_W'(1);
                    if (sweep_q == SWEEP_LAST) state_q <= fifo_empty ? IDLE : DRAIN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fb_addr_out    = fb_addr_q;
    assign fb_data_out    = fb_data_q;
    assign fb_we_out      = fb_we_q;
    assign busy_out       = (state_q != IDLE) | ~fifo_empty | s1_valid_q;
    assign drop_count_out = drop_q;
    assign clip_count_out = clip_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench: full-size instance for pixel path, clipping, full sweep and
// reset; a 16x8 instance keeps the FIFO-during-clear scenarios short.
module tb_framebuffer_writer;

    logic        clk;
    int          compared   = 0;
    int          mismatched = 0;

    // Full-size instance (320x180)
    logic        rst_n, valid, clr, we, busy;
    logic [10:0] h;
    logic [9:0]  v;
    logic [15:0] color, clr_color, addr, data, drop, clip;

    // Small instance (16x8, 128-pixel sweep)
    logic        s_rst_n, s_valid, s_clr, s_we, s_busy;
    logic [10:0] s_h;
    logic [9:0]  s_v;
    logic [15:0] s_color, s_clr_color, s_addr, s_data, s_drop, s_clip;

    logic [15:0] s_log_addr[$];
    logic [15:0] s_log_data[$];

    framebuffer_writer u_dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .hcount_in      (h),
        .vcount_in      (v),
        .data_valid_in  (valid),
        .color_in       (color),
        .clear_in       (clr),
        .clear_color_in (clr_color),
        .fb_addr_out    (addr),
        .fb_data_out    (data),
        .fb_we_out      (we),
        .busy_out       (busy),
        .drop_count_out (drop),
        .clip_count_out (clip)
    );

    framebuffer_writer #(
        .H_RES (16),
        .V_RES (8)
    ) u_small (
        .clk_in         (clk),
        .rst_in         (s_rst_n),
        .hcount_in      (s_h),
        .vcount_in      (s_v),
        .data_valid_in  (s_valid),
        .color_in       (s_color),
        .clear_in       (s_clr),
        .clear_color_in (s_clr_color),
        .fb_addr_out    (s_addr),
        .fb_data_out    (s_data),
        .fb_we_out      (s_we),
        .busy_out       (s_busy),
        .drop_count_out (s_drop),
        .clip_count_out (s_clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (s_we === 1'b1) begin
            s_log_addr.push_back(s_addr);
            s_log_data.push_back(s_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_rst_n = 1'b0;
        valid = 1'b0; clr = 1'b0; h = '0; v = '0; color = '0; clr_color = '0;
        s_valid = 1'b0; s_clr = 1'b0; s_h = '0; s_v = '0; s_color = '0; s_clr_color = '0;
        #3;
        compared++; if (we !== 1'b0) begin mismatched++; $display("FAIL reset_we got=%b exp=0", we); end
        compared++; if (addr !== 16'h0) begin mismatched++; $display("FAIL reset_addr got=%h exp=0000", addr); end
        compared++; if (data !== 16'h0) begin mismatched++; $display("FAIL reset_data got=%h exp=0000", data); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got=%b exp=0", busy); end
        compared++; if (drop !== 16'h0 || clip !== 16'h0) begin
            mismatched++; $display("FAIL reset_counts drop=%h clip=%h exp=0000/0000", drop, clip);
        end
        step(); step();
        rst_n = 1'b1; s_rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_pixel();
        h = 11'd5; v = 10'd2; color = 16'hF800; valid = 1'b1;
        step();
        valid = 1'b0;
        compared++; if (we !== 1'b0) begin mismatched++; $display("FAIL pix_lat1 we=%b exp=0", we); end
        step();
        compared++; if (we !== 1'b0) begin mismatched++; $display("FAIL pix_lat2 we=%b exp=0", we); end
        step();
        compared++; if (we !== 1'b1 || addr !== 16'd645 || data !== 16'hF800) begin
            mismatched++; $display("FAIL pix_write we=%b addr=%0d data=%h exp=1/645/f800", we, addr, data);
        end
        begin
            int extra = 0;
            for (int c = 0; c < 6; c++) begin
                step();
                if (we === 1'b1) extra++;
            end
            compared++; if (extra !== 0) begin mismatched++; $display("FAIL pix_single extra_writes=%0d exp=0", extra); end
        end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL pix_busy got=%b exp=0", busy); end
    endtask

    task automatic test_clip();
        int writes = 0;
        h = 11'd320; v = 10'd0; color = 16'h1234; valid = 1'b1;
        step();
        h = 11'h7FE;
        step();
        valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (we === 1'b1) writes++;
            step();
        end
        compared++; if (writes !== 0) begin mismatched++; $display("FAIL clip_writes got=%0d exp=0", writes); end
        compared++; if (clip !== 16'd2) begin mismatched++; $display("FAIL clip_count got=%0d exp=2", clip); end
        compared++; if (drop !== 16'd0) begin mismatched++; $display("FAIL clip_drop got=%0d exp=0", drop); end
    endtask

    task automatic test_clear_sweep();
        int n = 0;
        int bad = 0;
        clr_color = 16'h001F; clr = 1'b1;
        step();
        clr = 1'b0;
        compared++; if (we !== 1'b0) begin mismatched++; $display("FAIL sweep_entry we=%b exp=0", we); end
        step();
        compared++; if (we !== 1'b1 || addr !== 16'd0) begin
            mismatched++; $display("FAIL sweep_first we=%b addr=%0d exp=1/0", we, addr);
        end
        for (int c = 0; c < 60000 && we === 1'b1; c++) begin
            if (addr !== n[15:0] || data !== 16'h001F) begin
                if (bad == 0) $display("FAIL sweep_word idx=%0d addr=%0d data=%h exp=%0d/001f", n, addr, data, n);
                bad++;
            end
            n++;
            step();
        end
        compared++; if (n !== 57600) begin mismatched++; $display("FAIL sweep_len got=%0d exp=57600", n); end
        compared++; if (bad !== 0) begin mismatched++; $display("FAIL sweep_content bad=%0d exp=0", bad); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL sweep_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int bad_sweep = 0;
        int bad_pix = 0;
        s_log_addr.delete(); s_log_data.delete();
        s_clr_color = 16'hABCD; s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            s_h = 11'(i % 16); s_v = 10'(i / 16); s_color = 16'(16'h0100 + i); s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
        for (int c = 0; c < 400 && s_log_addr.size() < 144; c++) step();
        for (int c = 0; c < 8; c++) step();
        compared++; if (s_drop !== 16'd4) begin mismatched++; $display("FAIL b2b_drop got=%0d exp=4", s_drop); end
        compared++; if (s_log_addr.size() !== 144) begin
            mismatched++; $display("FAIL b2b_writes got=%0d exp=144", s_log_addr.size());
        end
        if (s_log_addr.size() >= 144) begin
            for (int i = 0; i < 128; i++)
                if (s_log_addr[i] !== 16'(i) || s_log_data[i] !== 16'hABCD) bad_sweep++;
            for (int i = 0; i < 16; i++)
                if (s_log_addr[128+i] !== 16'(i) || s_log_data[128+i] !== 16'(16'h0100 + i)) bad_pix++;
        end else begin
            bad_sweep = -1; bad_pix = -1;
        end
        compared++; if (bad_sweep !== 0) begin mismatched++; $display("FAIL b2b_sweep bad=%0d exp=0", bad_sweep); end
        compared++; if (bad_pix !== 0) begin mismatched++; $display("FAIL b2b_order bad=%0d exp=0", bad_pix); end
        compared++; if (s_busy !== 1'b0) begin mismatched++; $display("FAIL b2b_busy got=%b exp=0", s_busy); end
    endtask

    task automatic test_clear_coincident();
        int bad = 0;
        bit seen = 1'b0;
        s_log_addr.delete(); s_log_data.delete();
        s_clr_color = 16'h1111; s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            s_h = 11'(i); s_v = 10'd1; s_color = 16'(16'hAAA0 + i); s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (s_we === 1'b1 && s_addr === 16'd127) seen = 1'b1;
            else step();
        end
        compared++; if (!seen) begin mismatched++; $display("FAIL coin_sweep_end timeout exp=addr 127"); end
        s_clr = 1'b1; s_clr_color = 16'h2222;
        s_h = 11'd7; s_v = 10'd3; s_color = 16'hBEEF; s_valid = 1'b1;
        step();
        s_clr = 1'b0; s_valid = 1'b0;
        for (int c = 0; c < 200; c++) step();
        compared++; if (s_log_addr.size() !== 257) begin
            mismatched++; $display("FAIL coin_writes got=%0d exp=257", s_log_addr.size());
        end
        if (s_log_addr.size() >= 257) begin
            for (int i = 0; i < 128; i++)
                if (s_log_addr[128+i] !== 16'(i) || s_log_data[128+i] !== 16'h2222) bad++;
        end else bad = -1;
        compared++; if (bad !== 0) begin mismatched++; $display("FAIL coin_sweep2 bad=%0d exp=0", bad); end
        compared++; if (s_log_addr.size() < 257 || s_log_addr[256] !== 16'd55 || s_log_data[256] !== 16'hBEEF) begin
            mismatched++;
            $display("FAIL coin_pixel got=%0d/%h exp=55/beef",
                     (s_log_addr.size() >= 257) ? s_log_addr[256] : 16'hFFFF,
                     (s_log_data.size() >= 257) ? s_log_data[256] : 16'hFFFF);
        end
        compared++; if (s_drop !== 16'd4) begin mismatched++; $display("FAIL coin_drop got=%0d exp=4", s_drop); end
    endtask

    task automatic test_reset_mid_sweep();
        bit seen = 1'b0;
        int writes = 0;
        clr_color = 16'h07E0; clr = 1'b1;
        step();
        clr = 1'b0;
        for (int c = 0; c < 1100 && !seen; c++) begin
            if (we === 1'b1 && addr === 16'd1000) seen = 1'b1;
            else step();
        end
        compared++; if (!seen) begin mismatched++; $display("FAIL rst_sweep_reach timeout exp=addr 1000"); end
        #2 rst_n = 1'b0;
        #1;
        compared++; if (we !== 1'b0 || addr !== 16'h0 || data !== 16'h0) begin
            mismatched++; $display("FAIL rst_mid_outputs we=%b addr=%0d data=%h exp=0/0/0000", we, addr, data);
        end
        compared++; if (busy !== 1'b0 || clip !== 16'h0) begin
            mismatched++; $display("FAIL rst_mid_state busy=%b clip=%0d exp=0/0", busy, clip);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (we === 1'b1) writes++;
        end
        compared++; if (writes !== 0) begin mismatched++; $display("FAIL rst_after_writes got=%0d exp=0", writes); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_after_busy got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_clip();
        test_clear_sweep();
        test_back_to_back();
        test_clear_coincident();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
